// File: rtl/sram_d_arbiter.sv
// sram_d_arbiter: two-master OBI arbiter with an ordered in-flight FIFO; `SRAM_ARB_ROUND_ROBIN_EN` selects round-robin, else fixed m0 priority.
// Zero added latency on request and response paths; s_req_o and both grants drop while the FIFO is full.
module sram_d_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int OUTST_W         = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        s_req_o,
  input  logic        s_gnt_i,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  input  logic        s_illegal_i,

  output logic        unexp_rsp_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [OUTST_W-1:0]         count;
  logic [PTR_W-1:0]           wptr;
  logic [PTR_W-1:0]           rptr;
  logic [MAX_OUTSTANDING-1:0] id_mem;
  logic [MAX_OUTSTANDING-1:0] err_mem;
  logic                       last_grant;
  logic                       sel;
  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       pop;
  logic                       head_id;
  logic                       head_err;
  logic                       rsp0;
  logic                       rsp1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign full  = (count == OUTST_W'(MAX_OUTSTANDING));
  assign empty = (count == '0);

  always_comb begin
    sel = 1'b0;
    if (m1_req_i && !m0_req_i) begin
      sel = 1'b1;
    end else if (m0_req_i && m1_req_i) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      sel = ~last_grant;
`else
      sel = 1'b0;
`endif
    end
  end

`ifndef SRAM_ARB_ROUND_ROBIN_EN
  // Fixed priority still tracks the last winner so the state matches the round-robin build.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // A pop in the same cycle does not lift the full stall.
  assign s_req_o  = (m0_req_i | m1_req_i) & ~full & ~rst_i;
  assign m0_gnt_o = s_gnt_i & s_req_o & ~sel;
  assign m1_gnt_o = s_gnt_i & s_req_o & sel;

  assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = sel ? m1_we_i    : m0_we_i;
  assign s_be_o    = sel ? m1_be_i    : m0_be_i;
  assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

  assign push = s_req_o & s_gnt_i;
  assign pop  = s_rvalid_i & ~empty & ~rst_i;

  assign head_id  = id_mem[rptr];
  assign head_err = err_mem[rptr];
  assign rsp0     = pop & ~head_id;
  assign rsp1     = pop & head_id;

  assign m0_rvalid_o = rsp0;
  assign m0_rdata_o  = rsp0 ? s_rdata_i : '0;
  assign m0_err_o    = rsp0 & head_err;
  assign m1_rvalid_o = rsp1;
  assign m1_rdata_o  = rsp1 ? s_rdata_i : '0;
  assign m1_err_o    = rsp1 & head_err;

  assign unexp_rsp_o = s_rvalid_i & empty & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      last_grant <= 1'b1;
    end else begin
      if (push) begin
        wptr       <= ptr_inc(wptr);
        last_grant <= sel;
      end
      if (pop) begin
        rptr <= ptr_inc(rptr);
      end
      if (push && !pop) begin
        count <= count + OUTST_W'(1);
      end else if (pop && !push) begin
        count <= count - OUTST_W'(1);
      end
    end
  end

  // Entry storage needs no reset: occupancy is tracked by count and the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem[wptr]  <= sel;
      err_mem[wptr] <= s_illegal_i;
    end
  end

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Self-checking bench for sram_d_arbiter: directed scenarios then random traffic against a queue-based model.
module tb_sram_d_arbiter;

  localparam int DEPTH = 2;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o, m0_err_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic [3:0]  m0_be_i;
  logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o, m1_err_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m1_be_i;
  logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i, s_illegal_i, unexp_rsp_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_be_o;

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of outstanding (master, err) pairs and the last winner.
  bit qid[$];
  bit qerr[$];
  bit last_w = 1'b1;

  always #5 clk_i = ~clk_i;

  sram_d_arbiter #(.MAX_OUTSTANDING(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .s_illegal_i(s_illegal_i), .unexp_rsp_o(unexp_rsp_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive inputs, check outputs at the falling edge, then advance the model.
  task automatic cyc(input bit rst, input bit r0, input bit r1, input bit gnt, input bit rv,
                     input bit ill, input logic [31:0] rd, input logic [31:0] a0,
                     input logic [31:0] a1);
    int  n;
    bit  full, sreq, sel, pop, hid, herr, acc;
    rst_i       = rst;
    m0_req_i    = r0;
    m1_req_i    = r1;
    s_gnt_i     = gnt;
    s_rvalid_i  = rv;
    s_illegal_i = ill;
    s_rdata_i   = rd;
    m0_addr_i   = a0;
    m1_addr_i   = a1;
    m0_we_i     = 1'($urandom);
    m1_we_i     = 1'($urandom);
    m0_be_i     = 4'($urandom);
    m1_be_i     = 4'($urandom);
    m0_wdata_i  = $urandom;
    m1_wdata_i  = $urandom;

    n    = qid.size();
    full = (n == DEPTH);
    sreq = !rst && (r0 || r1) && !full;
    if (r0 && r1) sel = RR ? !last_w : 1'b0;
    else          sel = r1;
    acc  = sreq && gnt;
    pop  = !rst && rv && (n > 0);
    hid  = pop ? qid[0] : 1'b0;
    herr = pop ? qerr[0] : 1'b0;

    @(negedge clk_i);
    chk("s_req",     32'(s_req_o),     32'(sreq));
    chk("m0_gnt",    32'(m0_gnt_o),    32'(acc && !sel));
    chk("m1_gnt",    32'(m1_gnt_o),    32'(acc && sel));
    chk("m0_rvalid", 32'(m0_rvalid_o), 32'(pop && !hid));
    chk("m1_rvalid", 32'(m1_rvalid_o), 32'(pop && hid));
    chk("m0_rdata",  m0_rdata_o,       (pop && !hid) ? rd : 32'h0);
    chk("m1_rdata",  m1_rdata_o,       (pop && hid) ? rd : 32'h0);
    chk("m0_err",    32'(m0_err_o),    32'(pop && !hid && herr));
    chk("m1_err",    32'(m1_err_o),    32'(pop && hid && herr));
    chk("unexp",     32'(unexp_rsp_o), 32'(!rst && rv && n == 0));
    if (!rst) begin
      chk("count",   32'(dut.count),   32'(n));
      chk("s_addr",  s_addr_o,         sel ? a1 : a0);
      chk("s_we",    32'(s_we_o),      32'(sel ? m1_we_i : m0_we_i));
      chk("s_be",    32'(s_be_o),      32'(sel ? m1_be_i : m0_be_i));
      chk("s_wdata", s_wdata_o,        sel ? m1_wdata_i : m0_wdata_i);
    end

    @(posedge clk_i);
    #1;
    if (rst) begin
      qid.delete();
      qerr.delete();
      last_w = 1'b1;
    end else begin
      if (pop) begin
        void'(qid.pop_front());
        void'(qerr.pop_front());
      end
      if (acc) begin
        qid.push_back(sel);
        qerr.push_back(ill);
        last_w = sel;
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
    s_illegal_i = 1'b0; s_rdata_i = '0; m0_addr_i = '0; m1_addr_i = '0; m0_we_i = 1'b0;
    m1_we_i = 1'b0; m0_be_i = '0; m1_be_i = '0; m0_wdata_i = '0; m1_wdata_i = '0;
    @(posedge clk_i);
    #1;

    // Reset: every input active, all outputs must stay quiet.
    cyc(1, 1, 1, 1, 1, 1, 32'hFFFF_FFFF, $urandom, $urandom);
    cyc(1, 1, 1, 1, 1, 1, 32'hFFFF_FFFF, $urandom, $urandom);

    // Single master read with 1-cycle response.
    cyc(0, 1, 0, 1, 0, 0, 32'h0, 32'h8000_0010, $urandom);
    cyc(0, 0, 0, 1, 1, 0, 32'h1234_5678, $urandom, $urandom);

    // Contention from reset for 4 cycles, then m0 drops its request.
    cyc(1, 0, 0, 0, 0, 0, 32'h0, $urandom, $urandom);
    cyc(0, 1, 1, 1, 0, 0, $urandom, $urandom, $urandom);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 1, 0, $urandom, $urandom, $urandom);
    cyc(0, 0, 1, 1, 1, 0, $urandom, $urandom, $urandom);
    cyc(0, 0, 0, 0, 1, 0, $urandom, $urandom, $urandom);

    // Back-to-back m0 then m1, responses returned in order.
    cyc(1, 0, 0, 0, 0, 0, 32'h0, $urandom, $urandom);
    cyc(0, 1, 0, 1, 0, 0, 32'h0, $urandom, $urandom);
    cyc(0, 0, 1, 1, 1, 0, 32'hAAAA_0000, $urandom, $urandom);
    cyc(0, 0, 0, 0, 1, 0, 32'hBBBB_1111, $urandom, $urandom);

    // Full stall: fill, withhold rvalid 3 cycles, pop cycle still blocked, grant after.
    cyc(0, 1, 0, 1, 0, 0, 32'h0, $urandom, $urandom);
    cyc(0, 0, 1, 1, 0, 0, 32'h0, $urandom, $urandom);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 0, 0, 32'h0, $urandom, $urandom);
    cyc(0, 1, 1, 1, 1, 0, 32'hC0DE_0001, $urandom, $urandom);
    cyc(0, 1, 1, 1, 1, 0, 32'hC0DE_0002, $urandom, $urandom);
    cyc(0, 0, 0, 0, 1, 0, 32'hC0DE_0003, $urandom, $urandom);

    // Illegal access captured and returned to m1.
    cyc(0, 0, 1, 1, 0, 1, 32'h0, $urandom, 32'h0000_0000);
    cyc(0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, $urandom, $urandom);

    // Reset the cycle after a grant; the stale response is flagged unexpected.
    cyc(0, 1, 0, 1, 0, 0, 32'h0, $urandom, $urandom);
    cyc(1, 0, 0, 0, 0, 0, 32'h0, $urandom, $urandom);
    cyc(0, 0, 0, 0, 1, 0, 32'hA5A5_A5A5, $urandom, $urandom);
    cyc(0, 0, 0, 0, 0, 0, 32'h0, $urandom, $urandom);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom),
          $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
          $urandom, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_d_arbiter.md
# sram_d_arbiter

Two-master OBI arbiter that sits directly upstream of the SRAM wrapper's data port (`sram_d_*`) and produces the muxed request stream it consumes. Master 0 is the core LSU data port; master 1 is the host/debug bridge. The arbiter:
- selects one requester per cycle;
- tracks outstanding transactions in a small ordered FIFO;
- routes each response (`rvalid`/`rdata`) and the captured `illegal_memory` flag back to the master that issued it.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 2, depth of the in-flight tracking FIFO (≥1; 2 sustains back-to-back traffic to a 1-cycle-latency slave)
- `OUTST_W`, `$clog2(MAX_OUTSTANDING+1)`, width of the occupancy counter

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk_i` in 1 — clock
- `rst_i` in 1 — synchronous active-high reset
- `m0_req_i` in 1 / `m0_gnt_o` out 1 — master 0 request/grant
- `m0_addr_i` in 32, `m0_we_i` in 1, `m0_be_i` in 4, `m0_wdata_i` in 32 — master 0 request payload
- `m0_rvalid_o` out 1, `m0_rdata_o` out 32, `m0_err_o` out 1 — master 0 response
- `m1_*` — identical set for master 1
- `s_req_o` out 1 / `s_gnt_i` in 1 — slave request/grant (to `sram_d_req_i`/`sram_d_gnt_o`)
- `s_addr_o` out 32, `s_we_o` out 1, `s_be_o` out 4, `s_wdata_o` out 32 — muxed payload
- `s_rvalid_i` in 1, `s_rdata_i` in 32 — slave response
- `s_illegal_i` in 1 — slave's combinational illegal-access flag, valid in the request cycle
- `unexp_rsp_o` out 1 — pulses when `s_rvalid_i` arrives with the FIFO empty

## Operation
- **Acceptance:** a transaction is accepted on a master when `mX_req_i && mX_gnt_o`. On the slave side it is accepted when `s_req_o && s_gnt_i`.
- **Full gating:** `full = (count == MAX_OUTSTANDING)`. While full:
  - `s_req_o` = 0;
  - both `mX_gnt_o` = 0.
  - Full blocks even when a pop occurs in the same cycle.
- **Selection** is combinational on current requests:
  - only one master requesting → that master selected;
  - both requesting → arbitration policy (see Configuration).
- **Slave request:** `s_req_o = (m0_req_i | m1_req_i) & ~full & ~rst_i`.
- **Payload mux:** `s_addr/we/be/wdata` follow the selected master. When neither master requests, they follow master 0.
- **Master grant:** `mX_gnt_o = s_gnt_i & s_req_o & sel==X`. The non-selected master sees `gnt` = 0 and must hold its request (OBI rule).
- **Push:** on slave acceptance, push entry `{id=sel, err=s_illegal_i}`. Update `last_grant <= sel`.
- **Pop:** on `s_rvalid_i` with FIFO non-empty, pop the head and route the response:
  - `mH_rvalid_o` = 1;
  - `mH_rdata_o = s_rdata_i`;
  - `mH_err_o = head.err`.
  - The other master's `rvalid`, `rdata` and `err` are 0.
- **Simultaneous push and pop:** allowed. Count is unchanged and ordering is preserved.
- **Unexpected response:** `s_rvalid_i` with FIFO empty → no master `rvalid`, `unexp_rsp_o` = 1 for that cycle.
- **Wrap-around:** read/write pointers wrap modulo `MAX_OUTSTANDING`.

## Timing
- Request path is combinational: zero added cycles from `mX_req_i` to `s_req_o`/`mX_gnt_o`.
- Response path is combinational from `s_rvalid_i`/`s_rdata_i` to `mX_*`. With the SRAM wrapper, master-observed latency is 1 cycle (grant in cycle N, `rvalid` in N+1).
- Sustained throughput is 1 transaction/cycle for `MAX_OUTSTANDING` ≥ 2. `MAX_OUTSTANDING` = 1 gives 1 per 2 cycles.
- **Reset values** (in the cycle `rst_i` is high):
  - all `gnt`/`rvalid`/`err` outputs = 0;
  - `s_req_o` = 0;
  - `unexp_rsp_o` = 0;
  - `rdata` outputs = 0.
  - Registered state: FIFO empty, `count` = 0, `last_grant` = 1 (master 0 wins the first contention).
- **Reset mid-operation:**
  - in-flight entries are discarded;
  - a slave `rvalid` arriving in the cycle after reset deassertion is dropped and raises `unexp_rsp_o`.

## Configuration
- Macro: `SRAM_ARB_ROUND_ROBIN_EN`.
- **Defined:** on contention, select the master that is not `last_grant` (alternating).
- **Undefined:** fixed priority, master 0 always wins on contention. `last_grant` is still maintained but unused.

## Test plan
- Single master: `m0` reads `0x8000_0010`, `s_gnt_i`=1, `s_rvalid_i` next cycle with `0x1234_5678` → `m0_rvalid_o`=1, `m0_rdata_o`=`0x1234_5678`, `m1_rvalid_o`=0.
- Contention for 4 cycles, both masters holding `req`:
  - RR enabled → grants m0, m1, m0, m1;
  - RR disabled → m0 ×4, m1 granted only after m0 drops `req`.
- Back-to-back interleaved responses: m0 then m1 accepted in consecutive cycles → `rvalid` returned to m0 then m1 in order; count never exceeds 1 with `MAX_OUTSTANDING`=2.
- Full stall: `MAX_OUTSTANDING`=1, slave withholds `rvalid` for 3 cycles → `s_req_o`=0 and both `gnt`=0 until the pop; the next grant occurs in the pop cycle+1.
- Illegal capture: m1 accesses `0x0000_0000` with `s_illegal_i`=1 → next-cycle `m1_rvalid_o`=1, `m1_err_o`=1, `m1_rdata_o`=`0xDEAD_BEEF`.
- Reset mid-flight: assert `rst_i` the cycle after a grant → no `mX_rvalid_o`; `unexp_rsp_o`=1 when the stale `rvalid` arrives; count=0.
